// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared constants and state encoding for the ASCON-128a control FSM.
package ascon_pack;

  localparam logic [3:0] ROUNDS_A_START = 4'd0;
  localparam logic [3:0] ROUNDS_B_START = 4'd4;
  localparam logic [3:0] LAST_ROUND     = 4'd11;

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, TAG
  } type_fsm_state;

endpackage

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// Round constant counter: loads the p12 or p8 start index and counts up to LAST_ROUND.
module round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       init_a_i,
  input  logic       init_b_i,
  input  logic       en_i,
  output logic [3:0] round_o
);

  logic [3:0] round_q, round_d;

  // Loads win over counting; the count saturates at the last round.
  always_comb begin
    round_d = round_q;
    if (init_a_i) begin
      round_d = ROUNDS_A_START;
    end else if (init_b_i) begin
      round_d = ROUNDS_B_START;
    end else if (en_i && (round_q != LAST_ROUND)) begin
      round_d = round_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      round_q <= '0;
    end else begin
      round_q <= round_d;
    end
  end

  assign round_o = round_q;

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128a encryption control FSM driving the permutation/XOR datapath.
// Build option ASCON_AD_EN adds the associated-data phase (WAIT_AD/AD).
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int unsigned NB_PT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       enable_o,
  output logic [3:0] round_o,
  output logic       input_mode_o,
  output logic       en_xor_begin_data_o,
  output logic       en_xor_begin_key_o,
  output logic       mode_xor_key_o,
  output logic       bypass_xor_end_o,
  output logic       en_xor_end_dom_o,
  output logic       en_reg_cipher_o,
  output logic       en_reg_tag_o,
  output logic       cipher_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [3:0] NB_LAST = 4'(NB_PT_BLOCKS);

  type_fsm_state state_q, state_d;
  logic [3:0]    blk_q, blk_d;
  logic [3:0]    blk_inc;
  logic          cipher_valid_q, done_q;
  logic          init_a, init_b;
  logic          last_round;

  round_counter u_round_counter (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .init_a_i (init_a),
    .init_b_i (init_b),
    .en_i     (enable_o),
    .round_o  (round_o)
  );

  assign last_round = (round_o == LAST_ROUND);
  assign blk_inc    = blk_q + 4'd1;

  always_comb begin
    state_d             = state_q;
    blk_d               = blk_q;
    init_a              = 1'b0;
    init_b              = 1'b0;
    data_ready_o        = 1'b0;
    enable_o            = 1'b0;
    input_mode_o        = 1'b0;
    en_xor_begin_data_o = 1'b0;
    en_xor_begin_key_o  = 1'b0;
    mode_xor_key_o      = 1'b0;
    bypass_xor_end_o    = 1'b1;
    en_xor_end_dom_o    = 1'b0;
    en_reg_cipher_o     = 1'b0;
    en_reg_tag_o        = 1'b0;
    busy_o              = 1'b1;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = INIT;
          init_a  = 1'b1;
          blk_d   = '0;
        end
      end
      INIT: begin
        enable_o     = 1'b1;
        input_mode_o = (round_o != ROUNDS_A_START);
        if (last_round) begin
          bypass_xor_end_o = 1'b0;
`ifdef ASCON_AD_EN
          state_d          = WAIT_AD;
`else
          // Without AD the empty-AD domain separation lands on the init phase.
          en_xor_end_dom_o = 1'b1;
          state_d          = WAIT_PT;
`endif
        end
      end
`ifdef ASCON_AD_EN
      WAIT_AD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          state_d = AD;
          init_b  = 1'b1;
        end
      end
      AD: begin
        enable_o            = 1'b1;
        input_mode_o        = 1'b1;
        en_xor_begin_data_o = (round_o == ROUNDS_B_START);
        if (last_round) begin
          en_xor_end_dom_o = 1'b1;
          state_d          = WAIT_PT;
        end
      end
`endif
      WAIT_PT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          blk_d = blk_inc;
          // The last plaintext block is absorbed by the finalisation phase.
          if (blk_inc == NB_LAST) begin
            state_d = FINAL;
            init_a  = 1'b1;
          end else begin
            state_d = PT;
            init_b  = 1'b1;
          end
        end
      end
      PT: begin
        enable_o            = 1'b1;
        input_mode_o        = 1'b1;
        en_xor_begin_data_o = (round_o == ROUNDS_B_START);
        en_reg_cipher_o     = (round_o == ROUNDS_B_START);
        if (last_round) begin
          state_d = WAIT_PT;
        end
      end
      FINAL: begin
        enable_o     = 1'b1;
        input_mode_o = 1'b1;
        if (round_o == ROUNDS_A_START) begin
          en_xor_begin_data_o = 1'b1;
          en_reg_cipher_o     = 1'b1;
          en_xor_begin_key_o  = 1'b1;
          mode_xor_key_o      = 1'b1;
        end
        if (last_round) begin
          bypass_xor_end_o = 1'b0;
          state_d          = TAG;
        end
      end
      TAG: begin
        en_reg_tag_o = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q        <= IDLE;
      blk_q          <= '0;
      cipher_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      blk_q          <= blk_d;
      cipher_valid_q <= en_reg_cipher_o;
      done_q         <= (state_q == TAG);
    end
  end

  assign cipher_valid_o = cipher_valid_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed testbench for ascon_ctrl_fsm; follows ASCON_AD_EN like the design.
module tb_ascon_ctrl_fsm;

  localparam int NB = 4;
`ifdef ASCON_AD_EN
  localparam int AD_CYC = 9;
`else
  localparam int AD_CYC = 0;
`endif
  // Sample index n = n-th cycle after the edge that captures start_i.
  localparam int DONE_N = 12 + AD_CYC + NB + (NB - 1) * 8 + 12 + 1 + 1;
  localparam int W_PT   = 13 + AD_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic       data_ready, enable, input_mode, xor_data, xor_key, mode_key;
  logic       bypass, dom, reg_cipher, reg_tag, cipher_valid, busy, done;
  logic [3:0] round;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ascon_ctrl_fsm #(.NB_PT_BLOCKS(NB)) dut (
    .clock_i             (clk),
    .resetb_i            (rst_n),
    .start_i             (start),
    .data_valid_i        (valid),
    .data_ready_o        (data_ready),
    .enable_o            (enable),
    .round_o             (round),
    .input_mode_o        (input_mode),
    .en_xor_begin_data_o (xor_data),
    .en_xor_begin_key_o  (xor_key),
    .mode_xor_key_o      (mode_key),
    .bypass_xor_end_o    (bypass),
    .en_xor_end_dom_o    (dom),
    .en_reg_cipher_o     (reg_cipher),
    .en_reg_tag_o        (reg_tag),
    .cipher_valid_o      (cipher_valid),
    .busy_o              (busy),
    .done_o              (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  function automatic logic [16:0] out_vec();
    return {data_ready, enable, round, input_mode, xor_data, xor_key, mode_key,
            bypass, dom, reg_cipher, reg_tag, cipher_valid, busy, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cipher_cnt, cvalid_cnt, done_cnt, final_n;
    logic prev_cipher;

    // Reset state
    #12;
    check_eq("reset_outputs", 32'(out_vec()), 32'h40);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("idle_outputs", 32'(out_vec()), 32'h40);

    // Full message, data_valid held high, start pulsed mid-message
    cipher_cnt = 0; cvalid_cnt = 0; done_cnt = 0; prev_cipher = 1'b0;
    start = 1'b1;
    valid = 1'b1;
    for (int n = 1; n <= DONE_N + 10; n++) begin
      tick();
      if (n == 1) start = 1'b0;
      if (n <= 12) begin
        check_eq($sformatf("init_round_n%0d", n), 32'(round), 32'(n - 1));
        check_eq($sformatf("init_enable_n%0d", n), 32'(enable), 32'd1);
        check_eq($sformatf("init_mode_n%0d", n), 32'(input_mode), 32'(n != 1));
      end
      if (n <= DONE_N + 2)
        check_eq($sformatf("bypass_n%0d", n), 32'(bypass), 32'(!(n == 12 || n == DONE_N - 2)));
      if (n == 12) check_eq("init_last_dom", 32'(dom), 32'(AD_CYC == 0));
`ifdef ASCON_AD_EN
      if (n == 21) check_eq("ad_last_dom", 32'({round, dom}), 32'({4'd11, 1'b1}));
`endif
      if (n == 13) check_eq("first_wait", 32'({data_ready, enable}), 32'b10);
      if (n == W_PT + 1)
        check_eq("pt1_round4", 32'({round, xor_data, reg_cipher}), 32'({4'd4, 2'b11}));
      if (reg_cipher) begin
        cipher_cnt++;
        check_eq($sformatf("cipher_round_n%0d", n), 32'(round == 4 || round == 0), 32'd1);
      end
      if (cipher_valid || prev_cipher) begin
        if (cipher_valid) cvalid_cnt++;
        check_eq($sformatf("cipher_valid_n%0d", n), 32'(cipher_valid), 32'(prev_cipher));
      end
      if (xor_key)
        check_eq("final_round0", 32'({mode_key, round, n == DONE_N - 13}), 32'({1'b1, 4'd0, 1'b1}));
      if (n == DONE_N - 1) check_eq("tag_cycle", 32'({reg_tag, busy, enable}), 32'b110);
      if (done) begin
        done_cnt++;
        check_eq("done_latency", 32'(n), 32'(DONE_N));
      end
      if (n == DONE_N) check_eq("idle_after_tag", 32'(busy), 32'd0);
      if (n == 16) start = 1'b1;
      else if (n == 17) start = 1'b0;
      prev_cipher = reg_cipher;
    end
    check_eq("done_count", 32'(done_cnt), 32'd1);
    check_eq("cipher_count", 32'(cipher_cnt), 32'(NB));
    check_eq("cipher_valid_count", 32'(cvalid_cnt), 32'(NB));
    check_eq("busy_end", 32'(busy), 32'd0);

    // Stall in WAIT_PT, then reset in the middle of FINAL
    final_n = 0;
    start = 1'b1;
    valid = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == 1) start = 1'b0;
`ifdef ASCON_AD_EN
      if (n == 13) valid = 1'b1;
      else if (n == 14) valid = 1'b0;
`endif
      if (n >= W_PT && n <= W_PT + 4)
        check_eq($sformatf("stall_n%0d", n), 32'({data_ready, enable, round}), 32'({2'b10, 4'd11}));
      if (n == W_PT + 4) valid = 1'b1;
      if (n == W_PT + 5)
        check_eq("resume_round4", 32'({enable, round, reg_cipher}), 32'({1'b1, 4'd4, 1'b1}));
      if (n == W_PT + 6) check_eq("resume_cipher_valid", 32'(cipher_valid), 32'd1);
      if (xor_key && final_n == 0) final_n = n;
      if (final_n > 0 && n == final_n + 6) begin
        check_eq("final_round6", 32'({enable, round, busy}), 32'({1'b1, 4'd6, 1'b1}));
        break;
      end
    end
    check_eq("final_reached", 32'(final_n != 0), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("reset_mid_final", 32'(out_vec()), 32'h40);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("idle_after_reset2", 32'(out_vec()), 32'h40);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart_init", 32'({enable, round, busy}), 32'({1'b1, 4'd0, 1'b1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
